// File: rtl/key_expand_seq.sv
// rtl/key_expand_seq.sv - AES-128 key expansion sequencer
// Shares one external combinational S-box via req/gnt; one SubWord byte per granted cycle.
module key_expand_seq #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         sbox_req,
  input  logic         sbox_gnt,
  output logic [7:0]   sbox_addr,
  input  logic [7:0]   sbox_data,
  output logic [127:0] round_key,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MIX  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] round_key_q, round_key_d;
  logic [3:0]   rk_idx_q, rk_idx_d;
  logic         rk_valid_q, rk_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [31:0]  temp_q, temp_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3, t, n0, n1, n2, n3;
  logic [4:0]   byte_lsb;
  logic [3:0]   rk_idx_inc;

  assign w0 = round_key_q[127:96];
  assign w1 = round_key_q[95:64];
  assign w2 = round_key_q[63:32];
  assign w3 = round_key_q[31:0];

  // cnt 0 addresses the MSB of RotWord(w3); byte position is 3-cnt, i.e. ~cnt for 2 bits
  assign rot_w3   = {w3[23:0], w3[31:24]};
  assign byte_lsb = {~cnt_q, 3'b000};

  assign t  = temp_q ^ {rcon_q, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_idx_inc = rk_idx_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    rk_idx_d    = rk_idx_q;
    rk_valid_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    rcon_d      = rcon_q;
    temp_d      = temp_q;
    sbox_req    = 1'b0;
    sbox_addr   = 8'h00;

    case (state_q)
      IDLE: begin
        if (start) begin
          round_key_d = key_in;
          rk_idx_d    = 4'd0;
          rk_valid_d  = 1'b1;
          busy_d      = 1'b1;
          rcon_d      = 8'h01;
          cnt_d       = 2'd0;
          state_d     = SUB;
        end
      end
      SUB: begin
        sbox_req  = 1'b1;
        sbox_addr = rot_w3[byte_lsb +: 8];
        if (sbox_gnt) begin
          temp_d[byte_lsb +: 8] = sbox_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = MIX;
          end
        end
      end
      MIX: begin
        round_key_d = {n0, n1, n2, n3};
        rk_idx_d    = rk_idx_inc;
        rk_valid_d  = 1'b1;
        rcon_d      = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
        if (rk_idx_inc == 4'(ROUNDS)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = SUB;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_key_q <= 128'h0;
      rk_idx_q    <= 4'd0;
      rk_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= 2'd0;
      rcon_q      <= 8'h01;
      temp_q      <= 32'h0;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      rk_idx_q    <= rk_idx_d;
      rk_valid_q  <= rk_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      rcon_q      <= rcon_d;
      temp_q      <= temp_d;
    end
  end

  assign round_key = round_key_q;
  assign rk_idx    = rk_idx_q;
  assign rk_valid  = rk_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_key_expand_seq.sv
// tb/tb_key_expand_seq.sv - self-checking bench for key_expand_seq
// S-box is generated from GF(2^8) inversion + affine map; round keys from the FIPS-197 word recurrence.
module tb_key_expand_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = 128'h0;
  logic         sbox_req;
  logic         sbox_gnt = 1'b1;
  logic [7:0]   sbox_addr;
  logic [7:0]   sbox_data;
  logic [127:0] round_key;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         busy;
  logic         done;

  key_expand_seq #(.ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .sbox_req(sbox_req), .sbox_gnt(sbox_gnt), .sbox_addr(sbox_addr), .sbox_data(sbox_data),
    .round_key(round_key), .rk_idx(rk_idx), .rk_valid(rk_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [7:0]   sbox_tab [256];
  // Ungranted cycles return garbage so a stall that wrongly latches data is visible
  assign sbox_data = sbox_gnt ? sbox_tab[sbox_addr] : ~sbox_tab[sbox_addr];

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;

  logic [127:0] model_keys [11];
  logic [127:0] cap_key [16];
  logic [3:0]   cap_idx [16];
  int           cap_edge [16];
  logic         cap_done [16];
  logic         cap_busy [16];
  logic [7:0]   addr_log [64];
  logic [7:0]   stall_addr [8];
  int ncap, nreq, nlook, nstall, dbl_pulse, start_edge;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic compute_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tw;
    logic [7:0]  rc [10];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {sbox_tab[tw[31:24]], sbox_tab[tw[23:16]], sbox_tab[tw[15:8]], sbox_tab[tw[7:0]]};
        tw = tw ^ {rc[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int r = 0; r < 11; r++) model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Expected S-box address of lookup number cnt for round key r (from key r-1)
  function automatic logic [7:0] exp_addr(input int r, input int cnt);
    logic [31:0] wl = model_keys[r-1][31:0];
    logic [31:0] rot = {wl[23:0], wl[31:24]};
    return rot[31 - 8*cnt -: 8];
  endfunction

  // Caller is at a negedge; start is sampled at the following posedge (edge 0 of the run)
  task automatic run_seq(input logic [127:0] key, input int stall_at, input int stall_len,
                         input int dist_at, input logic [127:0] dist_key);
    int rel;
    logic prev_v;
    key_in = key; start = 1'b1; sbox_gnt = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_edge = edge_cnt;
    ncap = 0; nreq = 0; nlook = 0; nstall = 0; dbl_pulse = 0; prev_v = 1'b0;
    for (int c = 0; c < 200; c++) begin
      rel = edge_cnt - start_edge;
      if (rk_valid && ncap < 16) begin
        cap_key[ncap] = round_key; cap_idx[ncap] = rk_idx; cap_edge[ncap] = rel;
        cap_done[ncap] = done; cap_busy[ncap] = busy;
        ncap++;
      end
      if (rk_valid && prev_v) dbl_pulse++;
      prev_v = rk_valid;
      sbox_gnt = !((rel + 1) >= stall_at && (rel + 1) < stall_at + stall_len);
      if (sbox_req) nreq++;
      if (sbox_req && sbox_gnt && nlook < 64) begin addr_log[nlook] = sbox_addr; nlook++; end
      if (sbox_req && !sbox_gnt && nstall < 8) begin stall_addr[nstall] = sbox_addr; nstall++; end
      start  = ((rel + 1) == dist_at);
      key_in = start ? dist_key : key;
      if (done) break;
      @(negedge clk);
    end
    start = 1'b0; sbox_gnt = 1'b1; key_in = key;
  endtask

  task automatic test_reset;
    checks++; if (round_key !== 128'h0) begin errors++; $display("FAIL reset_round_key got %h exp 0", round_key); end
    checks++; if (rk_idx !== 4'd0) begin errors++; $display("FAIL reset_rk_idx got %0d exp 0", rk_idx); end
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid got %b exp 0", rk_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (sbox_req !== 1'b0) begin errors++; $display("FAIL reset_sbox_req got %b exp 0", sbox_req); end
    checks++; if (sbox_addr !== 8'h00) begin errors++; $display("FAIL reset_sbox_addr got %h exp 00", sbox_addr); end
  endtask

  task automatic test_fips;
    compute_model(FIPS_KEY);
    run_seq(FIPS_KEY, 0, 0, -1, 128'h0);
    checks++; if (ncap !== 11) begin errors++; $display("FAIL fips_pulses got %0d exp 11", ncap); end
    for (int k = 0; k < 11 && k < ncap; k++) begin
      checks++; if (cap_idx[k] !== 4'(k) || cap_key[k] !== model_keys[k] || cap_edge[k] !== 5*k) begin
        errors++; $display("FAIL fips_key%0d got idx %0d key %h edge %0d exp idx %0d key %h edge %0d",
                           k, cap_idx[k], cap_key[k], cap_edge[k], k, model_keys[k], 5*k);
      end
      checks++; if (cap_done[k] !== (k == 10) || cap_busy[k] !== (k != 10)) begin
        errors++; $display("FAIL fips_flags%0d got done %b busy %b exp done %b busy %b",
                           k, cap_done[k], cap_busy[k], k == 10, k != 10);
      end
    end
    checks++; if (cap_key[0] !== FIPS_KEY) begin errors++; $display("FAIL fips_echo got %h exp %h", cap_key[0], FIPS_KEY); end
    checks++; if (cap_key[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      errors++; $display("FAIL fips_rk1 got %h exp a0fafe1788542cb123a339392a6c7605", cap_key[1]); end
    checks++; if (cap_key[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++; $display("FAIL fips_rk10 got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", cap_key[10]); end
    checks++; if (nreq !== 40 || nlook !== 40) begin errors++; $display("FAIL fips_req_cycles got %0d/%0d exp 40/40", nreq, nlook); end
    for (int i = 0; i < 40 && i < nlook; i++) begin
      checks++; if (addr_log[i] !== exp_addr(i/4 + 1, i%4)) begin
        errors++; $display("FAIL fips_addr%0d got %h exp %h", i, addr_log[i], exp_addr(i/4 + 1, i%4)); end
    end
    checks++; if (dbl_pulse !== 0) begin errors++; $display("FAIL fips_double_pulse got %0d exp 0", dbl_pulse); end
  endtask

  task automatic test_zero_key;
    compute_model(128'h0);
    run_seq(128'h0, 0, 0, -1, 128'h0);
    checks++; if (ncap !== 11) begin errors++; $display("FAIL zero_pulses got %0d exp 11", ncap); end
    checks++; if (cap_key[1] !== 128'h62636363626363636263636362636363) begin
      errors++; $display("FAIL zero_rk1 got %h exp 62636363626363636263636362636363", cap_key[1]); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (addr_log[i] !== 8'h00) begin errors++; $display("FAIL zero_addr%0d got %h exp 00", i, addr_log[i]); end
    end
    for (int k = 2; k < 11 && k < ncap; k++) begin
      checks++; if (cap_key[k] !== model_keys[k]) begin
        errors++; $display("FAIL zero_key%0d got %h exp %h", k, cap_key[k], model_keys[k]); end
    end
  endtask

  task automatic test_stall;
    compute_model(FIPS_KEY);
    run_seq(FIPS_KEY, 18, 3, -1, 128'h0);
    checks++; if (ncap !== 11) begin errors++; $display("FAIL stall_pulses got %0d exp 11", ncap); end
    for (int k = 0; k < 11 && k < ncap; k++) begin
      checks++; if (cap_key[k] !== model_keys[k] || cap_edge[k] !== 5*k + (k >= 4 ? 3 : 0)) begin
        errors++; $display("FAIL stall_key%0d got key %h edge %0d exp key %h edge %0d",
                           k, cap_key[k], cap_edge[k], model_keys[k], 5*k + (k >= 4 ? 3 : 0));
      end
    end
    checks++; if (nstall !== 3 || nreq !== 43) begin
      errors++; $display("FAIL stall_cycles got stall %0d req %0d exp stall 3 req 43", nstall, nreq); end
    for (int i = 0; i < 3 && i < nstall; i++) begin
      checks++; if (stall_addr[i] !== exp_addr(4, 2)) begin
        errors++; $display("FAIL stall_addr_hold%0d got %h exp %h", i, stall_addr[i], exp_addr(4, 2)); end
    end
  endtask

  task automatic test_ignore_start;
    compute_model(FIPS_KEY);
    run_seq(FIPS_KEY, 0, 0, 20, ~FIPS_KEY);
    checks++; if (ncap !== 11) begin errors++; $display("FAIL ignore_pulses got %0d exp 11", ncap); end
    for (int k = 0; k < 11 && k < ncap; k++) begin
      checks++; if (cap_key[k] !== model_keys[k] || cap_edge[k] !== 5*k) begin
        errors++; $display("FAIL ignore_key%0d got key %h edge %0d exp key %h edge %0d",
                           k, cap_key[k], cap_edge[k], model_keys[k], 5*k);
      end
    end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    int busy_seen = 0;
    key_in = FIPS_KEY; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (26) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (round_key !== 128'h0 || rk_idx !== 4'd0 || rk_valid !== 1'b0 || busy !== 1'b0 ||
                  done !== 1'b0 || sbox_req !== 1'b0 || sbox_addr !== 8'h00) begin
      errors++; $display("FAIL rst_mid_outputs got key %h idx %0d v %b busy %b done %b req %b addr %h exp all 0",
                         round_key, rk_idx, rk_valid, busy, done, sbox_req, sbox_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (rk_valid) pulses++;
      if (busy) busy_seen++;
    end
    checks++; if (pulses !== 0 || busy_seen !== 0) begin
      errors++; $display("FAIL rst_mid_quiet got pulses %0d busy %0d exp 0 0", pulses, busy_seen); end
    compute_model(FIPS_KEY);
    run_seq(FIPS_KEY, 0, 0, -1, 128'h0);
    checks++; if (ncap !== 11) begin errors++; $display("FAIL rst_mid_rerun_pulses got %0d exp 11", ncap); end
    for (int k = 0; k < 11 && k < ncap; k++) begin
      checks++; if (cap_idx[k] !== 4'(k) || cap_key[k] !== model_keys[k] || cap_edge[k] !== 5*k) begin
        errors++; $display("FAIL rst_mid_key%0d got idx %0d key %h edge %0d exp %0d %h %0d",
                           k, cap_idx[k], cap_key[k], cap_edge[k], k, model_keys[k], 5*k);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] key2;
    key2 = {$urandom, $urandom, $urandom, $urandom};
    run_seq(FIPS_KEY, 0, 0, 50, 128'h0);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || ncap !== 11) begin
      errors++; $display("FAIL b2b_first_end got done %b busy %b pulses %0d exp 1 0 11", done, busy, ncap); end
    compute_model(key2);
    run_seq(key2, 0, 0, -1, 128'h0);
    checks++; if (ncap !== 11) begin errors++; $display("FAIL b2b_second_pulses got %0d exp 11", ncap); end
    for (int k = 0; k < 11 && k < ncap; k++) begin
      checks++; if (cap_idx[k] !== 4'(k) || cap_key[k] !== model_keys[k] || cap_edge[k] !== 5*k) begin
        errors++; $display("FAIL b2b_key%0d got idx %0d key %h edge %0d exp %0d %h %0d",
                           k, cap_idx[k], cap_key[k], cap_edge[k], k, model_keys[k], 5*k);
      end
    end
  endtask

  task automatic test_random;
    logic [127:0] key;
    int s_at, s_len, e;
    for (int it = 0; it < 4; it++) begin
      key   = {$urandom, $urandom, $urandom, $urandom};
      s_at  = 5 * $urandom_range(0, 9) + $urandom_range(1, 4);
      s_len = $urandom_range(0, 3);
      compute_model(key);
      @(negedge clk);
      run_seq(key, s_at, s_len, -1, 128'h0);
      checks++; if (ncap !== 11 || nreq !== 40 + s_len) begin
        errors++; $display("FAIL rand%0d_counts got pulses %0d req %0d exp 11 %0d", it, ncap, nreq, 40 + s_len); end
      for (int k = 0; k < 11 && k < ncap; k++) begin
        e = 5*k + ((s_len > 0 && 5*k > s_at) ? s_len : 0);
        checks++; if (cap_idx[k] !== 4'(k) || cap_key[k] !== model_keys[k] || cap_edge[k] !== e) begin
          errors++; $display("FAIL rand%0d_key%0d got idx %0d key %h edge %0d exp %0d %h %0d",
                             it, k, cap_idx[k], cap_key[k], cap_edge[k], k, model_keys[k], e);
        end
      end
      for (int i = 0; i < nstall; i++) begin
        checks++; if (stall_addr[i] !== exp_addr(s_at/5 + 1, s_at%5 - 1)) begin
          errors++; $display("FAIL rand%0d_stall_addr got %h exp %h", it, stall_addr[i], exp_addr(s_at/5 + 1, s_at%5 - 1)); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_f(8'(i));
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_fips;
    @(negedge clk);
    test_zero_key;
    @(negedge clk);
    test_stall;
    @(negedge clk);
    test_ignore_start;
    @(negedge clk);
    test_reset_mid;
    @(negedge clk);
    test_back_to_back;
    test_random;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
